// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings: transfer/burst codes, response values and the
// slave data-phase state encoding used by the memory slaves.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } slave_state_e;

endpackage

// File: rtl/ahb_slave_ram.sv
// Byte-wide RAM for the AHB memory slave: synchronous write, asynchronous
// read, contents survive reset.
module ahb_slave_ram #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  hclk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [7:0]            wdata_i,
    output logic [7:0]            rdata_o
);

    logic [7:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge hclk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite byte memory slave: pipelined transfers, WAIT_STATES wait cycles
// before each OKAY data phase, two-cycle ERROR for addresses beyond the RAM.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       hsel,
    input  logic [9:0] haddr,
    input  logic       hwrite,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic [7:0] hwdata,
    input  logic       hready,
    output logic [7:0] hrdata,
    output logic       hreadyout,
    output logic       hresp
);

    localparam logic [10:0] MEM_BYTES = 11'(2**DEPTH_LOG2);
    localparam logic [2:0]  WCNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_e state_q, state_d;
    logic [2:0]   wcnt_q, wcnt_d;
    logic [9:0]   addr_q, addr_d;
    logic         wr_q, wr_d;

    logic         accept;
    logic         in_range;
    logic         ram_we;
    logic [7:0]   ram_rdata;
    logic         unused_bits;

    assign accept   = hsel & hready & htrans[1];
    assign in_range = ({1'b0, haddr} < MEM_BYTES);

    // Burst type and the SEQ/NONSEQ distinction do not affect this slave;
    // only the low address bits index the RAM.
    assign unused_bits = ^{hburst, htrans[0], addr_q};

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = 8'h00;
        ram_we    = 1'b0;

        case (state_q)
            ST_IDLE, ST_ACCESS, ST_ERR2: begin
                if (state_q == ST_ACCESS) begin
                    ram_we = wr_q;
                    if (!wr_q) begin
                        hrdata = ram_rdata;
                    end
                end
                if (state_q == ST_ERR2) begin
                    hresp = HRESP_ERROR;
                end
                // Closing edge of a data phase doubles as the next address phase.
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d = haddr;
                    wr_d   = hwrite;
                    if (!in_range) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WCNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (wcnt_q == 3'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
            addr_q  <= 10'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

    ahb_slave_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .hclk    (hclk),
        .we_i    (ram_we),
        .addr_i  (addr_q[DEPTH_LOG2-1:0]),
        .wdata_i (hwdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: three instances with 0, 1 and 2 wait states, a
// directed vector table, reset corner case and randomized traffic vs a model.
module tb_ahb_mem_slave;
    import ahb_pkg::*;

    localparam int NDUT = 3;
    localparam int DLOG = 6;
    localparam int MEMB = 64;

    typedef struct {
        logic [1:0] trans;
        logic       write;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       auto_exp;
        logic       exp_err;
        logic [7:0] exp_rd;
    } xfer_t;

    typedef struct {
        int         k;
        logic [1:0] trans;
        logic       write;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       exp_err;
        logic [7:0] exp_rd;
        logic       brk;
    } vec_t;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic       hsel_s      [NDUT];
    logic [9:0] haddr_s     [NDUT];
    logic       hwrite_s    [NDUT];
    logic [1:0] htrans_s    [NDUT];
    logic [2:0] hburst_s    [NDUT];
    logic [7:0] hwdata_s    [NDUT];
    logic       hready_s    [NDUT];
    logic [7:0] hrdata_s    [NDUT];
    logic       hreadyout_s [NDUT];
    logic       hresp_s     [NDUT];

    logic [7:0] model [NDUT][MEMB];
    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            assign hready_s[gi] = hreadyout_s[gi];
            ahb_mem_slave #(
                .DEPTH_LOG2  (DLOG),
                .WAIT_STATES (gi)
            ) u_dut (
                .hclk      (hclk),
                .hresetn   (hresetn),
                .hsel      (hsel_s[gi]),
                .haddr     (haddr_s[gi]),
                .hwrite    (hwrite_s[gi]),
                .htrans    (htrans_s[gi]),
                .hburst    (hburst_s[gi]),
                .hwdata    (hwdata_s[gi]),
                .hready    (hready_s[gi]),
                .hrdata    (hrdata_s[gi]),
                .hreadyout (hreadyout_s[gi]),
                .hresp     (hresp_s[gi])
            );
        end
    endgenerate

    function automatic logic [9:0] bus_out(int k);
        return {hreadyout_s[k], hresp_s[k], hrdata_s[k]};
    endfunction

    task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ready=%0b resp=%0b rdata=%02h, expected ready=%0b resp=%0b rdata=%02h",
                     name, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic drive_idle(int k);
        hsel_s[k]   = 1'b0;
        htrans_s[k] = HTRANS_IDLE;
        haddr_s[k]  = 10'd0;
        hwrite_s[k] = 1'b0;
        hburst_s[k] = HBURST_SINGLE;
    endtask

    task automatic drive_addr(int k, xfer_t x);
        hsel_s[k]   = 1'b1;
        htrans_s[k] = x.trans;
        haddr_s[k]  = x.addr;
        hwrite_s[k] = x.write;
        hburst_s[k] = HBURST_INCR;
    endtask

    // Pipelined master: address of transfer i+1 is presented during the data
    // phase of transfer i and taken on the edge that closes it.
    task automatic run_seq(int k, input xfer_t seq[$]);
        int n;
        n = seq.size();
        drive_addr(k, seq[0]);
        for (int i = 0; i < n; i++) begin
            int         len;
            logic       err;
            logic [7:0] rd;
            @(posedge hclk);
            #1;
            if (seq[i].auto_exp) begin
                err = seq[i].trans[1] && (int'(seq[i].addr) >= MEMB);
                rd  = (seq[i].trans[1] && !err && !seq[i].write) ? model[k][seq[i].addr[5:0]] : 8'h00;
            end else begin
                err = seq[i].exp_err;
                rd  = seq[i].exp_rd;
            end
            if (i + 1 < n) drive_addr(k, seq[i+1]);
            else           drive_idle(k);
            hwdata_s[k] = seq[i].wdata;
            len = err ? 2 : (seq[i].trans[1] ? k + 1 : 1);
            for (int c = 0; c < len; c++) begin
                logic [9:0] exp;
                if (c > 0) begin
                    @(posedge hclk);
                    #1;
                end
                @(negedge hclk);
                if (err)              exp = (c == 0) ? 10'h100 : 10'h300;
                else if (c < len - 1) exp = 10'h000;
                else                  exp = {2'b10, rd};
                chk($sformatf("dut%0d addr=%03h cyc%0d", k, seq[i].addr, c), bus_out(k), exp);
            end
            if (seq[i].trans[1] && seq[i].write && !err)
                model[k][seq[i].addr[5:0]] = seq[i].wdata;
            $display("ws=%0d trans=%0d %s addr=%03h wdata=%02h exp_err=%0b exp_rd=%02h",
                     k, seq[i].trans, seq[i].write ? "W" : "R", seq[i].addr, seq[i].wdata, err, rd);
        end
        @(posedge hclk);
        #1;
    endtask

    function automatic xfer_t mkx(logic [1:0] t, logic w, logic [9:0] a, logic [7:0] d);
        xfer_t x;
        x.trans    = t;
        x.write    = w;
        x.addr     = a;
        x.wdata    = d;
        x.auto_exp = 1'b1;
        x.exp_err  = 1'b0;
        x.exp_rd   = 8'h00;
        return x;
    endfunction

    function automatic vec_t v(int k, logic [1:0] t, logic w, logic [9:0] a, logic [7:0] d,
                               logic e, logic [7:0] r, logic b);
        vec_t x;
        x.k = k; x.trans = t; x.write = w; x.addr = a; x.wdata = d;
        x.exp_err = e; x.exp_rd = r; x.brk = b;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[$];
        xfer_t q[$];
        xfer_t x;

        hresetn = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            drive_idle(k);
            hwdata_s[k] = 8'h00;
        end
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        for (int k = 0; k < NDUT; k++) chk($sformatf("reset dut%0d", k), bus_out(k), 10'h200);
        hresetn = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        for (int k = 0; k < NDUT; k++) chk($sformatf("post_reset dut%0d", k), bus_out(k), 10'h200);

        // Fill every RAM with known bytes so later reads are well defined.
        for (int k = 0; k < NDUT; k++) begin
            for (int b = 0; b < MEMB / 8; b++) begin
                q = {};
                for (int j = 0; j < 8; j++)
                    q.push_back(mkx(j == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 10'(b * 8 + j), 8'($urandom)));
                run_seq(k, q);
            end
        end

        // Directed table: k, trans, write, addr, wdata, exp_err, exp_rdata, end-of-burst
        vt.push_back(v(1, HTRANS_NONSEQ, 1, 10'h010, 8'hA5, 0, 8'h00, 1));
        vt.push_back(v(1, HTRANS_NONSEQ, 0, 10'h010, 8'h00, 0, 8'hA5, 1));
        vt.push_back(v(0, HTRANS_NONSEQ, 1, 10'h020, 8'h11, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_SEQ,    1, 10'h021, 8'h22, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_SEQ,    1, 10'h022, 8'h33, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_SEQ,    1, 10'h023, 8'h44, 0, 8'h00, 1));
        vt.push_back(v(0, HTRANS_NONSEQ, 0, 10'h020, 8'h00, 0, 8'h11, 0));
        vt.push_back(v(0, HTRANS_SEQ,    0, 10'h021, 8'h00, 0, 8'h22, 0));
        vt.push_back(v(0, HTRANS_SEQ,    0, 10'h022, 8'h00, 0, 8'h33, 0));
        vt.push_back(v(0, HTRANS_SEQ,    0, 10'h023, 8'h00, 0, 8'h44, 1));
        vt.push_back(v(1, HTRANS_NONSEQ, 1, 10'h000, 8'h77, 0, 8'h00, 0));
        vt.push_back(v(1, HTRANS_NONSEQ, 1, 10'h040, 8'hFF, 1, 8'h00, 0));
        vt.push_back(v(1, HTRANS_NONSEQ, 0, 10'h000, 8'h00, 0, 8'h77, 0));
        vt.push_back(v(1, HTRANS_NONSEQ, 0, 10'h3FF, 8'h00, 1, 8'h00, 0));
        vt.push_back(v(1, HTRANS_NONSEQ, 1, 10'h03F, 8'h9E, 0, 8'h00, 0));
        vt.push_back(v(1, HTRANS_NONSEQ, 0, 10'h03F, 8'h00, 0, 8'h9E, 1));
        vt.push_back(v(0, HTRANS_NONSEQ, 1, 10'h032, 8'h56, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_NONSEQ, 1, 10'h030, 8'h12, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_BUSY,   1, 10'h032, 8'hEE, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_SEQ,    1, 10'h031, 8'h34, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_IDLE,   1, 10'h032, 8'hEE, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_NONSEQ, 0, 10'h030, 8'h00, 0, 8'h12, 0));
        vt.push_back(v(0, HTRANS_BUSY,   0, 10'h031, 8'h00, 0, 8'h00, 0));
        vt.push_back(v(0, HTRANS_SEQ,    0, 10'h031, 8'h00, 0, 8'h34, 0));
        vt.push_back(v(0, HTRANS_SEQ,    0, 10'h032, 8'h00, 0, 8'h56, 1));
        vt.push_back(v(2, HTRANS_NONSEQ, 1, 10'h003, 8'h5A, 0, 8'h00, 0));
        vt.push_back(v(2, HTRANS_NONSEQ, 0, 10'h003, 8'h00, 0, 8'h5A, 1));

        q = {};
        for (int i = 0; i < vt.size(); i++) begin
            x = mkx(vt[i].trans, vt[i].write, vt[i].addr, vt[i].wdata);
            x.auto_exp = 1'b0;
            x.exp_err  = vt[i].exp_err;
            x.exp_rd   = vt[i].exp_rd;
            q.push_back(x);
            if (vt[i].brk) begin
                run_seq(vt[i].k, q);
                q = {};
            end
        end

        // Reset during the wait cycles of a write: the write must be dropped.
        q = {};
        q.push_back(mkx(HTRANS_NONSEQ, 1'b1, 10'h005, 8'h3C));
        run_seq(2, q);
        hsel_s[2]   = 1'b1;
        htrans_s[2] = HTRANS_NONSEQ;
        hwrite_s[2] = 1'b1;
        haddr_s[2]  = 10'h005;
        @(posedge hclk);
        #1;
        drive_idle(2);
        hwdata_s[2] = 8'hC3;
        @(negedge hclk);
        chk("rst_in_wait before", bus_out(2), 10'h000);
        #1;
        hresetn = 1'b0;
        #1;
        chk("rst_in_wait async", bus_out(2), 10'h200);
        @(posedge hclk);
        @(negedge hclk);
        chk("rst_in_wait held", bus_out(2), 10'h200);
        hresetn = 1'b1;
        $display("ws=2 reset asserted during write wait to 005");
        q = {};
        x = mkx(HTRANS_NONSEQ, 1'b0, 10'h005, 8'h00);
        x.auto_exp = 1'b0;
        x.exp_rd   = 8'h3C;
        q.push_back(x);
        run_seq(2, q);

        // Randomized bursts checked against the byte-array model.
        for (int k = 0; k < NDUT; k++) begin
            for (int b = 0; b < 40; b++) begin
                int len;
                len = $urandom_range(1, 4);
                q = {};
                for (int j = 0; j < len; j++) begin
                    int         r;
                    logic [1:0] t;
                    logic [9:0] a;
                    r = $urandom_range(0, 9);
                    if (r == 0)      t = HTRANS_IDLE;
                    else if (r == 1) t = HTRANS_BUSY;
                    else             t = (j == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                    if ($urandom_range(0, 9) == 0) a = 10'($urandom_range(MEMB, 1023));
                    else                           a = 10'($urandom_range(0, MEMB - 1));
                    q.push_back(mkx(t, 1'($urandom_range(0, 1)), a, 8'($urandom)));
                end
                run_seq(k, q);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

AHB-Lite byte-wide memory slave that sits directly downstream of the FPGA AHB master, on one of its two slave ports (hsel_1 / hsel_2, selected by address bit 10). It accepts pipelined single and burst transfers from the master, stores write data in an internal RAM, and returns read data with hreadyout / hresp into the response multiplexor. It provides configurable wait states and a two-cycle ERROR response for out-of-range addresses.

## Interface

- DEPTH_LOG2, 6: RAM is 2^DEPTH_LOG2 bytes; implemented addresses are 0 .. 2^DEPTH_LOG2-1.
- WAIT_STATES, 1: wait cycles (hreadyout=0) inserted before every OKAY data phase; legal range 0..7.

- hclk  input  1  system clock; all state changes on its rising edge.
- hresetn  input  1  asynchronous, active-low reset.
- hsel  input  1  slave select from the address decoder.
- haddr  input  10  transfer address (address phase).
- hwrite  input  1  1 = write, 0 = read (address phase).
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hburst  input  3  burst type; accepted, not used for address generation.
- hwdata  input  8  write data (data phase).
- hready  input  1  bus-level ready (muxed hreadyout of the active slave).
- hrdata  output  8  read data.
- hreadyout  output  1  this slave's ready.
- hresp  output  1  0 = OKAY, 1 = ERROR.

## Operation

- Transfer accepted on a rising edge when hsel=1, hready=1, htrans[1]=1 (NONSEQ/SEQ); haddr and hwrite latched into addr_q / wr_q.
- IDLE or BUSY with hsel=1 and hready=1: no access; next cycle zero-wait OKAY.
- States: IDLE, WAIT, ACCESS, ERR1, ERR2.
- On acceptance: haddr >= 2^DEPTH_LOG2 -> ERR1; else if WAIT_STATES=0 -> ACCESS; else -> WAIT with wcnt loaded with WAIT_STATES-1.
- WAIT: hreadyout=0, hresp=0; wcnt decrements; at wcnt=0 -> ACCESS.
- ACCESS: hreadyout=1, hresp=0. Read: hrdata = mem[addr_q[DEPTH_LOG2-1:0]]. Write: mem written with hwdata on the edge closing ACCESS.
- ERR1: hreadyout=0, hresp=1; -> ERR2. ERR2: hreadyout=1, hresp=1; no RAM write.
- Leaving ACCESS or ERR2: new acceptance on the same edge (pipelined back-to-back) follows the acceptance rules; otherwise -> IDLE.
- IDLE: hreadyout=1, hresp=0, hrdata=0.
- hrdata is 0 in every state except ACCESS with wr_q=0.
- Read after write to same address in the next transfer returns the new byte.
- Upper haddr bits (including bit 10) are ignored except for the range check.

## Timing

- Reset (async assert, sync-to-clock deassert): state=IDLE, hreadyout=1, hresp=0, hrdata=0, wcnt=0. RAM contents not cleared.
- Reset mid-transfer: in-flight write is dropped; returns to IDLE immediately.
- Data-phase length: WAIT_STATES+1 cycles OKAY; exactly 2 cycles ERROR.
- Zero-wait burst (WAIT_STATES=0): one beat per cycle, no bubbles.
- hsel deasserted while hready=0: ignored; the current data phase completes.

## Structure

- Shared package ahb_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes, HRESP OKAY/ERROR, and the slave state encoding, for reuse by the master and the second slave.
- One sub-module: ahb_slave_ram (2^DEPTH_LOG2 x 8, synchronous write, asynchronous read, no reset).
- Control FSM, wait counter and address/control registers stay in ahb_mem_slave.

## Test plan

- Reset: hresetn=0 mid-WAIT -> hreadyout=1, hresp=0, hrdata=0 immediately; no write committed.
- Single write 0xA5 to 0x010, then read 0x010 (WAIT_STATES=1) -> each data phase hreadyout 0 then 1; read hrdata=0xA5, hresp=0.
- INCR4 burst writes 0x11,0x22,0x33,0x44 to 0x020-0x023 with WAIT_STATES=0 -> four consecutive hreadyout=1 cycles; readback burst returns the same bytes in order.
- Access to 0x040 (DEPTH_LOG2=6) -> hreadyout=0/hresp=1, then hreadyout=1/hresp=1; a write of 0xFF leaves mem[0x00] unchanged.
- BUSY inserted mid-burst and IDLE with hsel=1 -> zero-wait OKAY, no RAM change, hrdata=0.
- Back-to-back write 0x5A to 0x003 then read 0x003 (WAIT_STATES=2) -> read data phase returns 0x5A after 2 wait cycles.
